vending_fsm: RTL and testbench

- Control FSM of the vending machine. It accepts coins, tracks the accumulated credit, handles buy and cancel requests, and sequences the vend and refund phases.
- It produces the registered 3-bit `status` code consumed directly by the downstream LED-decode stage, plus pulse and credit outputs for the display and dispensing logic.
- It is the single owner of the machine state; every other block treats `status` as read-only.

---
 rtl/vending_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_vending_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm.sv
// -----------------------------------------------------------------------------
// vending_fsm
//
// Control FSM of the vending machine. It accepts coins, tracks the accumulated
// credit, handles buy and cancel requests, and sequences the vend and refund
// phases. It is the single owner of the machine state. The state register
// drives the `status` code directly, so the LED-decode stage sees a registered
// value. All other outputs are registered too.
//
// Optional feature (compile-time macro VEND_TIMEOUT_EN):
//   When defined, the FSM refunds the credit after TIMEOUT_CYCLES cycles of
//   inactivity in LOW/EXACT/OVER. When undefined, credit is held indefinitely.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   power_sw     in   power switch level, 1 = on
//   coin_in      in   one-cycle strobe, a coin is presented
//   coin_val     in   [1:0] coin value: 01 = 1 unit, 10 = 2 units, else invalid
//   buy          in   one-cycle buy request
//   cancel       in   one-cycle cancel/refund request
//   status       out  [2:0] machine state code
//   credit       out  [CREDIT_W-1:0] accumulated credit
//   change       out  [CREDIT_W-1:0] amount being returned (valid in REFUND)
//   vend_pulse   out  one-cycle strobe to the dispenser
//   change_valid out  one-cycle strobe to the coin returner
//   coin_reject  out  one-cycle strobe, presented coin not accepted
// -----------------------------------------------------------------------------
module vending_fsm #(
  parameter int PRICE          = 3,
  parameter int CREDIT_W       = 4,
  parameter int MAX_CREDIT     = 15,
  parameter int VEND_CYCLES    = 8,
  parameter int REFUND_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power_sw,
  input  logic                coin_in,
  input  logic [1:0]          coin_val,
  input  logic                buy,
  input  logic                cancel,
  output logic [2:0]          status,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                vend_pulse,
  output logic                change_valid,
  output logic                coin_reject
);

  typedef enum logic [2:0] {
    S_OFF     = 3'b000,
    S_IDLE    = 3'b001,
    S_LOW     = 3'b010,
    S_EXACT   = 3'b011,
    S_OVER    = 3'b100,
    S_VEND    = 3'b101,
    S_REFUND  = 3'b110,
    S_ILLEGAL = 3'b111
  } state_e;

  // One counter serves VEND, REFUND and the timeout, so it is sized for the
  // longest of the three.
  localparam int CNT_MAX_VR = (VEND_CYCLES > REFUND_CYCLES) ? VEND_CYCLES : REFUND_CYCLES;
  localparam int CNT_MAX    = (TIMEOUT_CYCLES > CNT_MAX_VR) ? TIMEOUT_CYCLES : CNT_MAX_VR;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    VEND_LAST   = CNT_W'(VEND_CYCLES - 1);
  localparam logic [CNT_W-1:0]    REFUND_LAST = CNT_W'(REFUND_CYCLES - 1);
`ifdef VEND_TIMEOUT_EN
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C       = (CREDIT_W + 1)'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vend_pulse_q, vend_pulse_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;

  // One extra bit on the sum keeps the MAX_CREDIT comparison exact.
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic                go_refund;

  assign sum     = {1'b0, credit_q} + {{(CREDIT_W - 1){1'b0}}, coin_val};
  assign coin_ok = coin_in && ((coin_val == 2'b01) || (coin_val == 2'b10)) && (sum <= MAX_C);

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    cnt_d          = cnt_q;
    vend_pulse_d   = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = coin_in;   // any coin is rejected unless a branch accepts it
    go_refund      = 1'b0;

    case (state_q)
      S_OFF: begin
        if (power_sw) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_IDLE, S_LOW, S_EXACT, S_OVER: begin
        if (!power_sw) begin
          if (state_q == S_IDLE) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else begin
            go_refund = 1'b1;
          end
        end else if (cancel && (credit_q != '0)) begin
          go_refund = 1'b1;
        end else if (buy && ((state_q == S_EXACT) || (state_q == S_OVER))) begin
          state_d      = S_VEND;
          change_d     = credit_q - PRICE_C;
          credit_d     = '0;
          vend_pulse_d = 1'b1;
          cnt_d        = '0;
        end else if (coin_ok) begin
          credit_d      = sum[CREDIT_W-1:0];
          coin_reject_d = 1'b0;
          cnt_d         = '0;
          if (sum[CREDIT_W-1:0] < PRICE_C)       state_d = S_LOW;
          else if (sum[CREDIT_W-1:0] == PRICE_C) state_d = S_EXACT;
          else                                   state_d = S_OVER;
        end
`ifdef VEND_TIMEOUT_EN
        // Ignored buy/cancel strobes hold the timer; only true silence counts.
        else if ((state_q != S_IDLE) && !buy && !cancel) begin
          if (cnt_q == TIMEOUT_LAST) go_refund = 1'b1;
          else                       cnt_d     = cnt_q + CNT_W'(1);
        end
`endif

        if (go_refund) begin
          state_d        = S_REFUND;
          change_d       = credit_q;
          credit_d       = '0;
          change_valid_d = 1'b1;
          cnt_d          = '0;
        end
      end

      S_VEND: begin
        if (cnt_q == VEND_LAST) begin
          cnt_d = '0;
          if (change_q != '0) begin
            state_d        = S_REFUND;
            change_valid_d = 1'b1;
          end else begin
            state_d = power_sw ? S_IDLE : S_OFF;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REFUND: begin
        credit_d = '0;
        if (cnt_q == REFUND_LAST) begin
          change_d = '0;
          cnt_d    = '0;
          state_d  = power_sw ? S_IDLE : S_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable code 111: fall back to a clean OFF.
        state_d  = S_OFF;
        credit_d = '0;
        change_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_OFF;
      credit_q       <= '0;
      change_q       <= '0;
      cnt_q          <= '0;
      vend_pulse_q   <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      cnt_q          <= cnt_d;
      vend_pulse_q   <= vend_pulse_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign status       = state_q;
  assign credit       = credit_q;
  assign change       = change_q;
  assign vend_pulse   = vend_pulse_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vending_fsm.sv
// -----------------------------------------------------------------------------
// tb_vending_fsm
//
// Scenario tasks drive one cycle at a time through drive(). Each call pushes
// the outputs expected right after that edge onto a scoreboard queue. A
// monitor pops one entry #1 after every rising clock edge, and also after any
// falling edge of rst_n, and compares it with the DUT outputs via check().
// -----------------------------------------------------------------------------
module tb_vending_fsm;

  localparam logic [2:0] OFF = 3'd0, IDL = 3'd1, LOW = 3'd2, EXA = 3'd3,
                         OVR = 3'd4, VND = 3'd5, RFD = 3'd6;

  logic       clk;
  logic       rst_n;
  logic       power_sw;
  logic       coin_in;
  logic [1:0] coin_val;
  logic       buy;
  logic       cancel;
  logic [2:0] status;
  logic [3:0] credit;
  logic [3:0] change;
  logic       vend_pulse;
  logic       change_valid;
  logic       coin_reject;

  typedef struct {
    string       name;
    logic [13:0] v;   // {status, credit, change, vend_pulse, change_valid, coin_reject}
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  vending_fsm #(
    .PRICE(3), .CREDIT_W(4), .MAX_CREDIT(15),
    .VEND_CYCLES(8), .REFUND_CYCLES(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .power_sw     (power_sw),
    .coin_in      (coin_in),
    .coin_val     (coin_val),
    .buy          (buy),
    .cancel       (cancel),
    .status       (status),
    .credit       (credit),
    .change       (change),
    .vend_pulse   (vend_pulse),
    .change_valid (change_valid),
    .coin_reject  (coin_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {status, credit, change, vend_pulse, change_valid, coin_reject};
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got st=%b cr=%0d ch=%0d vp/cv/rj=%b, want st=%b cr=%0d ch=%0d vp/cv/rj=%b",
               nm, act[13:11], act[10:7], act[6:3], act[2:0],
               exp_v[13:11], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
    end
  endtask

  // Scoreboard consumer.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, outs(), e.v);
    end
  end

  // One clock cycle of stimulus plus the outputs expected right after the edge.
  task automatic drive(input logic pw, input logic ci, input logic [1:0] cv,
                       input logic b, input logic c,
                       input logic [2:0] est, input logic [3:0] ecr, input logic [3:0] ech,
                       input logic evp, input logic ecv, input logic erj,
                       input string nm);
    exp_t e;
    @(negedge clk);
    power_sw = pw;
    coin_in  = ci;
    coin_val = cv;
    buy      = b;
    cancel   = c;
    e.name   = nm;
    e.v      = {est, ecr, ech, evp, ecv, erj};
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    coin_in  = 1'b0;
    buy      = 1'b0;
    cancel   = 1'b0;
  endtask

  task automatic idle_n(input int n, input logic pw, input logic [2:0] st,
                        input logic [3:0] cr, input logic [3:0] ch, input string nm);
    for (int i = 0; i < n; i++)
      drive(pw, 1'b0, 2'b00, 1'b0, 1'b0, st, cr, ch, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    power_sw = 1'b0;
    coin_in  = 1'b0;
    coin_val = 2'b00;
    buy      = 1'b0;
    cancel   = 1'b0;
    #2;
    check("reset_state", outs(), {OFF, 4'd0, 4'd0, 3'b000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_power_on();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, OFF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "off_coin_reject");
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, IDL, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "power_on_idle");
  endtask

  task automatic test_overpay_change();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, LOW, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "op_coin2_low");
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, OVR, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, "op_coin2_over");
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, VND, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, "op_buy_vend");
    idle_n(7, 1'b1, VND, 4'd0, 4'd1, "op_vend_hold");
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, RFD, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, "op_refund_entry");
    idle_n(7, 1'b1, RFD, 4'd0, 4'd1, "op_refund_hold");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "op_back_idle");
  endtask

  task automatic test_exact_buy();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, LOW, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, "ex_coin1_a");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, LOW, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "ex_coin1_b");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, EXA, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, "ex_coin1_exact");
    drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, VND, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, "ex_buy_beats_coin");
    // Buy, cancel and power loss are all ignored while vending.
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, VND, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "ex_vend_ignores");
    idle_n(6, 1'b1, VND, 4'd0, 4'd0, "ex_vend_hold");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "ex_direct_idle");
  endtask

  task automatic test_coin_reject();
    for (int i = 1; i <= 7; i++)
      drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, (i == 1) ? LOW : OVR, 4'(2 * i), 4'd0,
            1'b0, 1'b0, 1'b0, "cr_fill");
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, OVR, 4'd14, 4'd0, 1'b0, 1'b0, 1'b1, "cr_overflow_16");
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, OVR, 4'd14, 4'd0, 1'b0, 1'b0, 1'b1, "cr_invalid_11");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, OVR, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, "cr_reach_max");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, OVR, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, "cr_over_max");
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, OVR, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, "cr_invalid_00");
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, RFD, 4'd0, 4'd15, 1'b0, 1'b1, 1'b0, "cr_cancel_refund");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, RFD, 4'd0, 4'd15, 1'b0, 1'b0, 1'b1, "cr_refund_rejects");
    idle_n(6, 1'b1, RFD, 4'd0, 4'd15, "cr_refund_hold");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "cr_back_idle");
  endtask

  task automatic test_cancel_priority();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, LOW, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, "cp_idle_cancel_ign");
    drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, EXA, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, "cp_low_buy_ign");
    drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, RFD, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1, "cp_cancel_wins");
    idle_n(7, 1'b0, RFD, 4'd0, 4'd3, "cp_refund_pwr_off");
    idle_n(1, 1'b0, OFF, 4'd0, 4'd0, "cp_refund_to_off");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "cp_power_back");
  endtask

  task automatic test_power_loss();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, LOW, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "pl_coin2");
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, RFD, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, "pl_power_refund");
    idle_n(7, 1'b0, RFD, 4'd0, 4'd2, "pl_refund_hold");
    idle_n(1, 1'b0, OFF, 4'd0, 4'd0, "pl_to_off");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "pl_power_on");
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, OFF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "pl_idle_off");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "pl_power_on2");
  endtask

  task automatic test_reset_mid_vend();
    exp_t e;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, LOW, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "rv_coin2_a");
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, OVR, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, "rv_coin2_b");
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, VND, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, "rv_buy");
    idle_n(3, 1'b1, VND, 4'd0, 4'd1, "rv_vend_hold");
    // Checked 1 ns after rst_n falls, well before the next rising edge.
    @(negedge clk);
    e.name = "rv_async_reset";
    e.v    = {OFF, 4'd0, 4'd0, 3'b000};
    exp_q.push_back(e);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "rv_restart_idle");
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, LOW, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, "to_coin1");
`ifdef VEND_TIMEOUT_EN
    idle_n(19, 1'b1, LOW, 4'd1, 4'd0, "to_wait");
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, RFD, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, "to_expire_refund");
`else
    idle_n(30, 1'b1, LOW, 4'd1, 4'd0, "to_credit_held");
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, RFD, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, "to_cancel_refund");
`endif
    check("to_expired_wait", outs(), {RFD, 4'd0, 4'd1, 3'b010});
    idle_n(7, 1'b1, RFD, 4'd0, 4'd1, "to_refund_hold");
    idle_n(1, 1'b1, IDL, 4'd0, 4'd0, "to_back_idle");
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_overpay_change();
    test_exact_buy();
    test_coin_reject();
    test_cancel_priority();
    test_power_loss();
    test_reset_mid_vend();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
